matrix_display_arbiter: RTL and testbench
=========================================

Name: matrix_display_arbiter

Overview:
- Shares the single 8x8 LED dot-matrix (line/row drive) between up to NREQ pattern generators: time display, hourly-chime pattern, alarm pattern, and so on.
- Each generator scans only while its enable (linerow-style input) is high and outputs all-zero otherwise.
- This block grants the matrix to one requester at a time:
  - enforces a minimum display time per grant;
  - inserts a dark gap between owners;
  - muxes the owner's line/row onto the physical matrix pins.

Parameters:
- NREQ, 4, number of requesters (2..8); index 0 is highest priority.
- GW, 2, grant_id width = ceil(log2(NREQ)), minimum 1.
- HOLD_TICKS, 1000, minimum grant length in fs cycles (>=1).
- BLANK_TICKS, 8, dark gap between owners in fs cycles (>=1).
- CW, 16, width of the internal tick counter; must hold max(HOLD_TICKS, BLANK_TICKS)-1.

Ports:
- fs  in  1  scan clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  level request per generator.
- line_in  in  8*NREQ  generator line buses; requester k occupies bits [8k+7:8k].
- row_in  in  8*NREQ  generator row buses; same packing as line_in.
- en  out  NREQ  one-hot enable to generators (drives their linerow input).
- grant_id  out  GW  index of current owner; holds last owner in BLANK.
- busy  out  1  high whenever state is not IDLE.
- done  out  NREQ  one-cycle pulse on the owner's bit when its hold period expires.
- line  out  8  matrix line drive.
- row  out  8  matrix row drive.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; en=0, grant_id=0, busy=0, done=0, line=0, row=0;
  - counter=0; last-owner valid flag cleared.
  - Reset overrides any state, including mid-HOLD.
- All outputs are registered.
- line/row = line_in/row_in slice of grant_id sampled on the previous edge (1-cycle latency) while state=HOLD; 0 in IDLE and BLANK.
- States:
  - IDLE:
    - en=0.
    - If req!=0: owner = lowest set index; go to HOLD; en[owner]=1 from the same edge; counter=0.
    - Else stay in IDLE.
  - HOLD:
    - en[owner]=1 and counter increments each cycle.
    - New requests, including higher-priority ones, are ignored until expiry (no preemption).
    - req[owner] drops before or at expiry: go to BLANK next edge; no done pulse; drop wins over a same-cycle expiry.
    - Expiry (counter==HOLD_TICKS-1 and req[owner] still high): done[owner]=1 for one cycle. Then:
      - any other req bit set → go to BLANK, owner becomes last owner;
      - else → stay in HOLD, counter=0 (re-arm, en stays high without a gap).
  - BLANK:
    - en=0, line=row=0; counter counts 0..BLANK_TICKS-1.
    - On the final count, arbitrate on current req:
      - highest-priority set bit excluding the last owner;
      - if none, the last owner if its req is still set;
      - if req==0 → IDLE.
    - A winner enters HOLD with counter=0.
- Anti-starvation: an owner whose hold expired yields to any other pending requester. Under contention this rotates among requesters in priority order.
- Counter wraps to 0 on every state entry; it never free-runs past its terminal value.
- busy=1 in HOLD and BLANK.
- grant_id changes only on HOLD entry.
- en is never multi-hot. en and line/row are never nonzero during BLANK.

Test Plan (NREQ=4, HOLD_TICKS=4, BLANK_TICKS=2):
- Reset idle: rst for 2 cycles with req=4'b1111 → en=0, line=row=0, busy=0. First edge after rst release → en=4'b0001, grant_id=0, busy=1.
- Single requester, continuous: req=4'b0100, line_in slice 2=8'h01, row_in slice 2=8'h81:
  - en=4'b0100;
  - line=8'h01, row=8'h81 one cycle after en;
  - done[2] pulses every 4 cycles;
  - no BLANK gap (en never drops).
- Contention rotation: req=4'b0011 held high → owner 0 for 4 cycles, done[0] pulse, 2 dark cycles, owner 1 for 4 cycles, done[1], 2 dark cycles, owner 0 again.
- No preemption: owner 3 in HOLD cycle 1, req[0] asserts → en stays 4'b0100... corrected: en stays 4'b1000 until expiry, then 2-cycle BLANK, then en=4'b0001.
- Early release: owner 1, req[1] drops at counter=1 → BLANK next edge, done=0, line=row=0 for 2 cycles, then IDLE with busy=0 (req=0).
- Reset mid-HOLD: rst asserted at counter=2 → next edge all outputs 0, state IDLE, no done pulse. After release, arbitration restarts at priority 0.

Source files
------------

// File: rtl/matrix_display_arbiter_if.sv
// -----------------------------------------------------------------------------
// matrix_display_arbiter_if
// Bundles the signals between the pattern generators and the display arbiter.
//   req       : level request per generator (index 0 = highest priority)
//   line_in   : generator line buses, requester k on bits [8k+7:8k]
//   row_in    : generator row buses, same packing as line_in
//   en        : one-hot enable back to the generators
//   grant_id  : index of the current (or last) owner
//   busy      : arbiter is in HOLD or BLANK
//   done      : one-cycle pulse on the owner's bit when its hold expires
//   line, row : physical matrix drive
// master = generator side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface matrix_display_arbiter_if #(
   parameter int NREQ = 4,
   parameter int GW   = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] line_in;
   logic [8*NREQ-1:0] row_in;
   logic [NREQ-1:0]   en;
   logic [GW-1:0]     grant_id;
   logic              busy;
   logic [NREQ-1:0]   done;
   logic [7:0]        line;
   logic [7:0]        row;

   modport master (
      output req, line_in, row_in,
      input  en, grant_id, busy, done, line, row
   );

   modport slave (
      input  req, line_in, row_in,
      output en, grant_id, busy, done, line, row
   );
endinterface

// File: rtl/matrix_display_arbiter.sv
// -----------------------------------------------------------------------------
// matrix_display_arbiter
// Time-shares one 8x8 LED dot-matrix between NREQ pattern generators. One
// owner at a time holds the matrix for at least HOLD_TICKS scan cycles; a
// BLANK_TICKS dark gap separates different owners. An owner whose hold has
// expired yields to any other pending requester, so contention rotates.
// Ports:
//   fs   : scan clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of matrix_display_arbiter_if (req/line_in/row_in in,
//          en/grant_id/busy/done/line/row out, all outputs registered)
// -----------------------------------------------------------------------------
module matrix_display_arbiter #(
   parameter int NREQ        = 4,
   parameter int GW          = 2,
   parameter int HOLD_TICKS  = 1000,
   parameter int BLANK_TICKS = 8,
   parameter int CW          = 16
) (
   input  logic                     fs,
   input  logic                     rst,
   matrix_display_arbiter_if.slave  bus
);

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BLANK = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   grant_id_q, grant_id_d;
   logic            last_vld_q, last_vld_d;
   logic [NREQ-1:0] en_q, en_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            busy_q, busy_d;
   logic [7:0]      line_q, line_d;
   logic [7:0]      row_q, row_d;

   logic [NREQ-1:0] owner_mask;
   logic            owner_req;
   logic [NREQ-1:0] other_req;
   logic [NREQ-1:0] blank_cand;

   // Lowest set index wins (index 0 is highest priority).
   function automatic logic [GW-1:0] pick(input logic [NREQ-1:0] r);
      logic [GW-1:0] idx;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (r[k]) idx = GW'(k);
      end
      return idx;
   endfunction

   assign owner_mask = NREQ'(1) << grant_id_q;
   assign owner_req  = bus.req[grant_id_q];
   assign other_req  = bus.req & ~owner_mask;
   // In BLANK the previous owner only gets the matrix back if nobody else wants it.
   assign blank_cand = last_vld_q ? other_req : bus.req;

   // State register
   always_ff @(posedge fs) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         grant_id_q <= '0;
         last_vld_q <= 1'b0;
         en_q       <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         line_q     <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         grant_id_q <= grant_id_d;
         last_vld_q <= last_vld_d;
         en_q       <= en_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         line_q     <= line_d;
         row_q      <= row_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grant_id_d = grant_id_q;
      last_vld_d = last_vld_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d    = HOLD;
               grant_id_d = pick(bus.req);
               cnt_d      = '0;
            end
         end
         HOLD: begin
            // A dropped request ends the grant even on the expiry cycle.
            if (!owner_req) begin
               state_d    = BLANK;
               cnt_d      = '0;
               last_vld_d = 1'b1;
            end else if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               if (|other_req) begin
                  state_d    = BLANK;
                  last_vld_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d = '0;
               if (|blank_cand) begin
                  state_d    = HOLD;
                  grant_id_d = pick(blank_cand);
               end else if (|bus.req) begin
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic (registered next cycle)
   always_comb begin
      en_d   = '0;
      done_d = '0;
      line_d = '0;
      row_d  = '0;
      busy_d = (state_d != IDLE);
      if (state_d == HOLD) en_d = NREQ'(1) << grant_id_d;
      if (state_q == HOLD && owner_req && cnt_q == HOLD_LAST) done_d = owner_mask;
      // Mux only while the owner keeps the matrix across this edge, so the
      // pins stay dark on the entry edge and through the whole BLANK gap.
      if (state_q == HOLD && state_d == HOLD) begin
         line_d = bus.line_in[8*int'(grant_id_q) +: 8];
         row_d  = bus.row_in[8*int'(grant_id_q) +: 8];
      end
   end

   assign bus.en       = en_q;
   assign bus.grant_id = grant_id_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.line     = line_q;
   assign bus.row      = row_q;

endmodule

// File: tb/tb_matrix_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_matrix_display_arbiter
// Directed bench for matrix_display_arbiter with NREQ=4, HOLD_TICKS=4,
// BLANK_TICKS=2. Each step drives rst/req, queues the outputs expected after
// the next rising edge, then compares them one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_matrix_display_arbiter;

   typedef struct packed {
      logic [3:0] en;
      logic [1:0] gid;
      logic       busy;
      logic [3:0] done;
      logic [7:0] line;
      logic [7:0] row;
   } exp_t;

   logic fs;
   logic rst;
   exp_t sb[$];
   int   n_assert;
   int   n_fail;

   matrix_display_arbiter_if #(.NREQ(4), .GW(2)) bus ();

   matrix_display_arbiter #(
      .NREQ(4), .GW(2), .HOLD_TICKS(4), .BLANK_TICKS(2), .CW(16)
   ) dut (
      .fs  (fs),
      .rst (rst),
      .bus (bus)
   );

   initial fs = 1'b0;
   always #5 fs = ~fs;

   task automatic step(input logic r, input logic [3:0] rq,
                       input logic [3:0] e, input logic [1:0] g, input logic b,
                       input logic [3:0] d, input logic [7:0] l, input logic [7:0] rw,
                       input string tag);
      exp_t exp_v;
      exp_t obs;
      rst     = r;
      bus.req = rq;
      sb.push_back('{e, g, b, d, l, rw});
      @(posedge fs);
      #1;
      exp_v = sb.pop_front();
      obs   = '{bus.en, bus.grant_id, bus.busy, bus.done, bus.line, bus.row};
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed en=%b gid=%0d busy=%b done=%b line=%h row=%h, expected en=%b gid=%0d busy=%b done=%b line=%h row=%h",
                tag, obs.en, obs.gid, obs.busy, obs.done, obs.line, obs.row,
                exp_v.en, exp_v.gid, exp_v.busy, exp_v.done, exp_v.line, exp_v.row);
      end
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.req     = '0;
      bus.line_in = {8'h44, 8'h01, 8'h22, 8'h11};
      bus.row_in  = {8'hD4, 8'h81, 8'hB2, 8'hA1};

      // reset with all requests pending
      step(1, 4'b1111, 4'b0000, 2'd0, 0, 4'b0000, 8'h00, 8'h00, "rst0");
      step(1, 4'b1111, 4'b0000, 2'd0, 0, 4'b0000, 8'h00, 8'h00, "rst1");
      step(0, 4'b1111, 4'b0001, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "grant0");
      step(0, 4'b0100, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "drop0");
      step(0, 4'b0100, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "blank_a");
      step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 8'h00, 8'h00, "grant2");

      // single requester: re-arms every 4 cycles without a gap
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 3; c++)
            step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 8'h01, 8'h81, "hold2");
         step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0100, 8'h01, 8'h81, "done2");
      end

      // contention rotation 0 -> 1 -> 0
      step(0, 4'b0011, 4'b0000, 2'd2, 1, 4'b0000, 8'h00, 8'h00, "rel2");
      step(0, 4'b0011, 4'b0000, 2'd2, 1, 4'b0000, 8'h00, 8'h00, "blank_b");
      step(0, 4'b0011, 4'b0001, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "rot_own0");
      for (int c = 0; c < 3; c++)
         step(0, 4'b0011, 4'b0001, 2'd0, 1, 4'b0000, 8'h11, 8'hA1, "hold0");
      step(0, 4'b0011, 4'b0000, 2'd0, 1, 4'b0001, 8'h00, 8'h00, "done0");
      step(0, 4'b0011, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "dark0");
      step(0, 4'b0011, 4'b0010, 2'd1, 1, 4'b0000, 8'h00, 8'h00, "rot_own1");
      for (int c = 0; c < 3; c++)
         step(0, 4'b0011, 4'b0010, 2'd1, 1, 4'b0000, 8'h22, 8'hB2, "hold1");
      step(0, 4'b0011, 4'b0000, 2'd1, 1, 4'b0010, 8'h00, 8'h00, "done1");
      step(0, 4'b0011, 4'b0000, 2'd1, 1, 4'b0000, 8'h00, 8'h00, "dark1");
      step(0, 4'b0011, 4'b0001, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "rot_back0");

      // no preemption of owner 3 by requester 0
      step(0, 4'b1000, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "rel0");
      step(0, 4'b1000, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "blank_c");
      step(0, 4'b1000, 4'b1000, 2'd3, 1, 4'b0000, 8'h00, 8'h00, "grant3");
      step(0, 4'b1000, 4'b1000, 2'd3, 1, 4'b0000, 8'h44, 8'hD4, "hold3");
      step(0, 4'b1001, 4'b1000, 2'd3, 1, 4'b0000, 8'h44, 8'hD4, "nopreempt_a");
      step(0, 4'b1001, 4'b1000, 2'd3, 1, 4'b0000, 8'h44, 8'hD4, "nopreempt_b");
      step(0, 4'b1001, 4'b0000, 2'd3, 1, 4'b1000, 8'h00, 8'h00, "done3");
      step(0, 4'b1001, 4'b0000, 2'd3, 1, 4'b0000, 8'h00, 8'h00, "dark3");
      step(0, 4'b1001, 4'b0001, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "after3");

      // early release of owner 1 at counter 1, then back to idle
      step(0, 4'b0010, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "rel0b");
      step(0, 4'b0010, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "blank_d");
      step(0, 4'b0010, 4'b0010, 2'd1, 1, 4'b0000, 8'h00, 8'h00, "grant1");
      step(0, 4'b0010, 4'b0010, 2'd1, 1, 4'b0000, 8'h22, 8'hB2, "hold1b");
      step(0, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000, 8'h00, 8'h00, "early_rel");
      step(0, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000, 8'h00, 8'h00, "dark_e");
      step(0, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 8'h00, 8'h00, "idle_e");
      step(0, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 8'h00, 8'h00, "idle_hold");

      // reset in the middle of a hold, then restart at priority 0
      step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 8'h00, 8'h00, "grant2b");
      step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 8'h01, 8'h81, "hold2b_a");
      step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 8'h01, 8'h81, "hold2b_b");
      step(1, 4'b0100, 4'b0000, 2'd0, 0, 4'b0000, 8'h00, 8'h00, "rst_mid");
      step(0, 4'b0101, 4'b0001, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "restart0");
      for (int c = 0; c < 3; c++)
         step(0, 4'b0101, 4'b0001, 2'd0, 1, 4'b0000, 8'h11, 8'hA1, "hold0b");

      // request drop on the expiry cycle: no done pulse
      step(0, 4'b0100, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "drop_wins");
      step(0, 4'b0100, 4'b0000, 2'd0, 1, 4'b0000, 8'h00, 8'h00, "dark_d");
      step(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 8'h00, 8'h00, "grant2c");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
